jk_cmd_sequencer: RTL and testbench
===================================

// Module: jk_cmd_sequencer
// PURPOSE
//  Upstream driver for a bank of positive-edge JK flip-flops (inputs j, k, clk; no reset).
//  Buffers set/reset/toggle/hold commands in a small FIFO with a valid/ready handshake.
//  Issues each command as registered j/k vectors for a programmable number of cycles.
//  Keeps a shadow copy of the flop bank's expected Q.
// PARAMETERS
//  WIDTH  4  number of JK flops driven (bits in j, k, mask, q_shadow)
//  DEPTH  4  command FIFO entries; power of 2, >=2
//  REP_W  4  width of cmd_repeat; a command is applied for cmd_repeat+1 cycles
// PORTS
//  clk         in   1                    clock, all logic on posedge
//  rst         in   1                    synchronous reset, active-high
//  cmd_valid   in   1                    command offered
//  cmd_ready   out  1                    command can be accepted this cycle
//  cmd_op      in   2                    {j,k} code: 00 hold, 01 reset, 10 set, 11 toggle
//  cmd_mask    in   WIDTH                flops affected; unmasked bits get j=k=0
//  cmd_repeat  in   REP_W                extra cycles to apply the command
//  j           out  WIDTH                registered J vector to the flop bank
//  k           out  WIDTH                registered K vector to the flop bank
//  q_shadow    out  WIDTH                modelled Q of the flop bank
//  fifo_count  out  $clog2(DEPTH+1)      entries currently queued
//  busy        out  1                    state!=IDLE or fifo_count!=0
// BEHAVIOUR
//  - Reset values: j=0, k=0, q_shadow=0, fifo_count=0, busy=0, state=IDLE. cmd_ready=0 while rst=1.
//  - Reset mid-operation flushes the FIFO and aborts the active command. j/k read 0 after that edge.
//  - Accept: a command is written on an edge where cmd_valid && cmd_ready.
//  - cmd_ready = !rst && fifo_count<DEPTH && state!=INIT. It is combinational, with no dependence on cmd_valid.
//  - Simultaneous push and pop: fifo_count unchanged. Push when full is impossible because ready=0.
//  - Pointers wrap modulo DEPTH.
//  - FSM states: IDLE, ISSUE, plus INIT (macro only).
//    IDLE: j=k=0. If FIFO non-empty, pop the head, load rep_cnt=cmd_repeat, and go to ISSUE.
//    ISSUE: j = mask & {WIDTH{op[1]}}, k = mask & {WIDTH{op[0]}}, registered.
//      Each edge: if rep_cnt!=0, decrement it.
//      Else, if FIFO non-empty, pop the next command with no gap cycle. Otherwise go to IDLE and drive j=k=0.
//  - Latency: command accepted at edge E into an empty FIFO in IDLE → j/k show it after edge E+1.
//    The flop bank samples it at edge E+2.
//  - Back-to-back commands: zero idle cycles between the last cycle of one and the first of the next.
//  - Hold op (00) with any mask drives j=k=0 for cmd_repeat+1 cycles; use it as a timed delay.
//  - q_shadow: on every edge with rst=0, each bit updates from the current j/k pair:
//      00 keep, 01 clear, 10 set, 11 invert.
//    This equals the flop bank's Q provided the bank started in a known state.
//  - rep_cnt arithmetic is unsigned REP_W. cmd_repeat=all-ones gives 2^REP_W issue cycles.
// CONFIGURATION
//  Macro JK_SEQ_INIT_EN:
//   Defined:
//    - After rst deasserts, enter INIT for exactly one cycle: j=0, k={WIDTH{1}}, cmd_ready=0.
//    - Then go to IDLE. This clears the reset-less flop bank so it matches q_shadow=0.
//    - Reset asserted during INIT restarts INIT after release.
//   Undefined:
//    - No INIT state; IDLE follows reset directly and cmd_ready=1 on the first cycle after reset.
//    - q_shadow matches the flop bank only after every bit has been set or reset by a command.
// TESTING (WIDTH=4, DEPTH=4, REP_W=4)
//  1. Reset: rst=1 for 2 cycles, then release (no macro) → j=k=0000, q_shadow=0000, fifo_count=0, busy=0.
//     cmd_ready=0 during rst, 1 after.
//  2. Set: op=10, mask=0101, repeat=0, accepted at edge E → j=0101, k=0000 for exactly one cycle after E+1.
//     Then j=k=0, q_shadow=0101, busy=0.
//  3. Toggle: from q_shadow=0101, op=11, mask=1111, repeat=2 → j=k=1111 for 3 cycles.
//     q_shadow goes 1010, 0101, 1010.
//  4. Full/back-to-back: push hold repeat=15, then 4 set commands on consecutive cycles.
//     → fifo_count reaches 4 and cmd_ready drops. A 6th valid command stalls until the first pop.
//     All sets issue with no gap cycles.
//  5. Reset mid-op: assert rst during cycle 2 of a toggle repeat=5 with 2 entries queued.
//     → after the edge: j=k=0, fifo_count=0, q_shadow=0000, state IDLE.
//  6. JK_SEQ_INIT_EN defined: release rst → one cycle j=0000, k=1111, cmd_ready=0, then cmd_ready=1.
//     q_shadow stays 0000.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// Command FIFO + issue FSM driving registered J/K vectors to a reset-less JK flop bank.
// Optional macro JK_SEQ_INIT_EN adds a one-cycle INIT state that clears the bank after reset.
module jk_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int REP_W = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic [WIDTH-1:0]           cmd_mask_i,
  input  logic [REP_W-1:0]           cmd_repeat_i,
  output logic [WIDTH-1:0]           j_o,
  output logic [WIDTH-1:0]           k_o,
  output logic [WIDTH-1:0]           q_shadow_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
  output logic                       busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, INIT} state_e;

`ifdef JK_SEQ_INIT_EN
  localparam state_e RST_STATE = INIT;
`else
  localparam state_e RST_STATE = IDLE;
`endif

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  j_q, j_d, k_q, k_d, q_q, q_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic              push, pop, init_act;

  logic [1:0]        op_mem_q   [DEPTH];
  logic [WIDTH-1:0]  mask_mem_q [DEPTH];
  logic [REP_W-1:0]  rep_mem_q  [DEPTH];

  assign cmd_ready_o = !rst_i && (cnt_q < FULL) && (state_q != INIT);
  assign push        = cmd_valid_i && cmd_ready_o;

  // INIT drives K high combinationally so the clear pulse lands in the first
  // cycle after release while j/k still read 0 throughout reset.
`ifdef JK_SEQ_INIT_EN
  assign init_act = (state_q == INIT) && !rst_i;
`else
  assign init_act = 1'b0;
`endif

  assign j_o          = j_q;
  assign k_o          = k_q | {WIDTH{init_act}};
  assign q_shadow_o   = q_q;
  assign fifo_count_o = cnt_q;
  assign busy_o       = (state_q == ISSUE) || (cnt_q != '0) || init_act;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    rep_d   = rep_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        j_d = '0;
        k_d = '0;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rep_q != '0) begin
          rep_d = rep_q - REP_W'(1);
        end else if (cnt_q != '0) begin
          pop = 1'b1;
        end else begin
          state_d = IDLE;
          j_d     = '0;
          k_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        j_d     = '0;
        k_d     = '0;
      end
    endcase
    if (pop) begin
      j_d   = mask_mem_q[rd_ptr_q] & {WIDTH{op_mem_q[rd_ptr_q][1]}};
      k_d   = mask_mem_q[rd_ptr_q] & {WIDTH{op_mem_q[rd_ptr_q][0]}};
      rep_d = rep_mem_q[rd_ptr_q];
    end
    // JK characteristic equation applied to what the bank sees this cycle.
    q_d   = (j_o & ~q_q) | (~k_o & q_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RST_STATE;
      j_q      <= '0;
      k_q      <= '0;
      q_q      <= '0;
      rep_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      k_q      <= k_d;
      q_q      <= q_d;
      rep_q    <= rep_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      op_mem_q[wr_ptr_q]   <= cmd_op_i;
      mask_mem_q[wr_ptr_q] <= cmd_mask_i;
      rep_mem_q[wr_ptr_q]  <= cmd_repeat_i;
    end
  end
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer (WIDTH=4, DEPTH=4, REP_W=4).
module tb_jk_cmd_sequencer;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [1:0] cmd_op_i = '0;
  logic [3:0] cmd_mask_i = '0;
  logic [3:0] cmd_repeat_i = '0;
  logic [3:0] j_o, k_o, q_shadow_o;
  logic [2:0] fifo_count_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;

  jk_cmd_sequencer #(.WIDTH(4), .DEPTH(4), .REP_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_mask_i(cmd_mask_i), .cmd_repeat_i(cmd_repeat_i),
    .j_o(j_o), .k_o(k_o), .q_shadow_o(q_shadow_o), .fifo_count_o(fifo_count_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [3:0] mask, input logic [3:0] rep);
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_mask_i = mask; cmd_repeat_i = rep;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", cmd_ready_o); end
    tick();
    checks++;
    if ({j_o, k_o, q_shadow_o, fifo_count_o, busy_o} !== 16'h0) begin
      errors++; $display("FAIL rst_vals: j=%b k=%b q=%b cnt=%0d busy=%b want all 0", j_o, k_o, q_shadow_o, fifo_count_o, busy_o);
    end
    rst_i = 1'b0;
    #1;
`ifdef JK_SEQ_INIT_EN
    checks++;
    if (cmd_ready_o !== 1'b0 || j_o !== 4'b0000 || k_o !== 4'b1111) begin
      errors++; $display("FAIL init_cycle: ready=%b j=%b k=%b want 0 0000 1111", cmd_ready_o, j_o, k_o);
    end
    tick();
    checks++;
    if (k_o !== 4'b0000 || q_shadow_o !== 4'b0000) begin
      errors++; $display("FAIL init_after: k=%b q=%b want 0000 0000", k_o, q_shadow_o);
    end
`endif
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", cmd_ready_o); end
  endtask

  task automatic test_set();
    push_cmd(2'b10, 4'b0101, 4'd0);
    checks++;
    if (fifo_count_o !== 3'd1 || j_o !== 4'b0000) begin
      errors++; $display("FAIL set_queued: cnt=%0d j=%b want 1 0000", fifo_count_o, j_o);
    end
    tick();
    checks++;
    if (j_o !== 4'b0101 || k_o !== 4'b0000 || busy_o !== 1'b1) begin
      errors++; $display("FAIL set_issue: j=%b k=%b busy=%b want 0101 0000 1", j_o, k_o, busy_o);
    end
    tick();
    checks++;
    if (j_o !== 4'b0000 || k_o !== 4'b0000 || q_shadow_o !== 4'b0101 || busy_o !== 1'b0) begin
      errors++; $display("FAIL set_done: j=%b k=%b q=%b busy=%b want 0000 0000 0101 0", j_o, k_o, q_shadow_o, busy_o);
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'b0101; exp_q[1] = 4'b1010; exp_q[2] = 4'b0101;
    push_cmd(2'b11, 4'b1111, 4'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (j_o !== 4'b1111 || k_o !== 4'b1111 || q_shadow_o !== exp_q[i]) begin
        errors++; $display("FAIL tog_cyc%0d: j=%b k=%b q=%b want 1111 1111 %b", i, j_o, k_o, q_shadow_o, exp_q[i]);
      end
    end
    tick();
    checks++;
    if (j_o !== 4'b0000 || k_o !== 4'b0000 || q_shadow_o !== 4'b1010) begin
      errors++; $display("FAIL tog_done: j=%b k=%b q=%b want 0000 0000 1010", j_o, k_o, q_shadow_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops   [5];
    logic [3:0] masks [5];
    logic [3:0] reps  [5];
    logic [3:0] ej, ek;
    logic       pre;
    int         acc_edge;
    ops[0] = 2'b00; masks[0] = 4'b1111; reps[0] = 4'd15;
    ops[1] = 2'b10; masks[1] = 4'b0001; reps[1] = 4'd0;
    ops[2] = 2'b10; masks[2] = 4'b0100; reps[2] = 4'd0;
    ops[3] = 2'b10; masks[3] = 4'b0010; reps[3] = 4'd0;
    ops[4] = 2'b10; masks[4] = 4'b1000; reps[4] = 4'd0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid_i = 1'b1; cmd_op_i = ops[i]; cmd_mask_i = masks[i]; cmd_repeat_i = reps[i];
      checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, cmd_ready_o); end
      tick();
    end
    cmd_op_i = 2'b01; cmd_mask_i = 4'b1111; cmd_repeat_i = 4'd0;
    checks++;
    if (fifo_count_o !== 3'd4 || cmd_ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_full: cnt=%0d ready=%b want 4 0", fifo_count_o, cmd_ready_o);
    end
    acc_edge = -1;
    for (int e = 5; e <= 22; e++) begin
      pre = cmd_valid_i && cmd_ready_o;
      tick();
      if (pre) begin cmd_valid_i = 1'b0; acc_edge = e; end
      ej = 4'b0000; ek = 4'b0000;
      case (e)
        17: ej = 4'b0001;
        18: ej = 4'b0100;
        19: ej = 4'b0010;
        20: ej = 4'b1000;
        21: ek = 4'b1111;
        default: ;
      endcase
      checks++;
      if (j_o !== ej || k_o !== ek) begin
        errors++; $display("FAIL b2b_e%0d: j=%b k=%b want %b %b", e, j_o, k_o, ej, ek);
      end
      if (e == 17) begin
        checks++; if (fifo_count_o !== 3'd3) begin errors++; $display("FAIL b2b_pop_cnt: got %0d want 3", fifo_count_o); end
      end
      if (e == 21) begin
        checks++; if (q_shadow_o !== 4'b1111) begin errors++; $display("FAIL b2b_q21: got %b want 1111", q_shadow_o); end
      end
      if (e == 22) begin
        checks++; if (q_shadow_o !== 4'b0000) begin errors++; $display("FAIL b2b_q22: got %b want 0000", q_shadow_o); end
      end
    end
    cmd_valid_i = 1'b0;
    checks++; if (acc_edge !== 18) begin errors++; $display("FAIL b2b_stall: accepted at edge %0d want 18", acc_edge); end
  endtask

  task automatic test_reset_midop();
    cmd_valid_i = 1'b1; cmd_op_i = 2'b11; cmd_mask_i = 4'b1111; cmd_repeat_i = 4'd5;
    tick();
    cmd_op_i = 2'b10; cmd_mask_i = 4'b0011; cmd_repeat_i = 4'd0;
    tick();
    checks++; if (j_o !== 4'b1111) begin errors++; $display("FAIL mid_cyc1: j=%b want 1111", j_o); end
    tick();
    checks++;
    if (fifo_count_o !== 3'd2 || q_shadow_o !== 4'b1111) begin
      errors++; $display("FAIL mid_cyc2: cnt=%0d q=%b want 2 1111", fifo_count_o, q_shadow_o);
    end
    cmd_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", cmd_ready_o); end
    tick();
    checks++;
    if ({j_o, k_o, q_shadow_o, fifo_count_o, busy_o} !== 16'h0) begin
      errors++; $display("FAIL mid_rst: j=%b k=%b q=%b cnt=%0d busy=%b want all 0", j_o, k_o, q_shadow_o, fifo_count_o, busy_o);
    end
    rst_i = 1'b0;
`ifdef JK_SEQ_INIT_EN
    tick();
`endif
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (j_o !== 4'b0000 || busy_o !== 1'b0 || fifo_count_o !== 3'd0 || cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL mid_flushed: j=%b busy=%b cnt=%0d ready=%b want 0000 0 0 1", j_o, busy_o, fifo_count_o, cmd_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
